// File: rtl/mshr_fifo_param.sv
// In-order miss status holding FIFO with concurrent per-entry latency countdown.
// Optional MSHR_STATS_EN adds allocation and stall event counters.
module mshr_fifo_param #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 27,
    parameter int WARP_W = 3,
    parameter int SCB_W  = 2,
    parameter int LAT_W  = 5,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int PTR_W = IDX_W + 1
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              req_valid,
    input  logic              req_hit_missbar,
    input  logic [SCB_W-1:0]  req_scbID,
    input  logic [WARP_W-1:0] req_warpID,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LAT_W-1:0]  req_latency,
    output logic              req_ready,
    output logic              fb_valid,
    input  logic              fb_ready,
    output logic [SCB_W-1:0]  fb_scbID,
    output logic [WARP_W-1:0] fb_warpID,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [PTR_W-1:0]  occupancy,
    output logic              full,
    output logic              empty,
    output logic              overflow_err
`ifdef MSHR_STATS_EN
    ,
    output logic [31:0]       stat_alloc,
    output logic [31:0]       stat_stall
`endif
);

    logic [PTR_W-1:0]  wp_q;
    logic [PTR_W-1:0]  rp_q;
    logic [IDX_W-1:0]  wp_idx;
    logic [IDX_W-1:0]  rp_idx;
    logic [SCB_W-1:0]  scb_q  [DEPTH];
    logic [WARP_W-1:0] warp_q [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [LAT_W-1:0]  cnt_q  [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic [IDX_W-1:0]  off;
    logic              miss;
    logic              push;
    logic              pop;
    logic [LAT_W-1:0]  lat_in;
    logic              ovf_q;

    assign wp_idx    = wp_q[IDX_W-1:0];
    assign rp_idx    = rp_q[IDX_W-1:0];
    assign occupancy = wp_q - rp_q;
    assign empty     = (occupancy == '0);
    assign full      = (occupancy == PTR_W'(DEPTH));
    assign req_ready = !full;

    assign miss   = req_valid & ~req_hit_missbar;
    assign push   = miss & ~full;
    assign lat_in = (req_latency == '0) ? LAT_W'(1) : req_latency;

    assign fb_valid  = !empty && (cnt_q[rp_idx] == LAT_W'(1));
    assign fb_scbID  = scb_q[rp_idx];
    assign fb_warpID = warp_q[rp_idx];
    assign fb_addr   = addr_q[rp_idx];
    assign pop       = fb_valid & fb_ready;

    assign overflow_err = ovf_q;

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        vld = '0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off    = IDX_W'(i) - rp_idx;
            vld[i] = ({1'b0, off} < occupancy);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            wp_q  <= '0;
            rp_q  <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (push) begin
                wp_q <= wp_q + PTR_W'(1);
            end
            if (pop) begin
                rp_q <= rp_q + PTR_W'(1);
            end
            if (miss && full) begin
                ovf_q <= 1'b1;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (wp_idx == IDX_W'(i))) begin
                    cnt_q[i] <= lat_in;
                end else if (vld[i] && (cnt_q[i] > LAT_W'(1))) begin
                    cnt_q[i] <= cnt_q[i] - LAT_W'(1);
                end
            end
        end
    end

    // Payload needs no reset: it is only observed while the slot is live.
    always_ff @(posedge clk) begin
        if (push) begin
            scb_q[wp_idx]  <= req_scbID;
            warp_q[wp_idx] <= req_warpID;
            addr_q[wp_idx] <= req_addr;
        end
    end

`ifdef MSHR_STATS_EN
    always_ff @(posedge clk) begin
        if (!resetb) begin
            stat_alloc <= '0;
            stat_stall <= '0;
        end else begin
            if (push) begin
                stat_alloc <= stat_alloc + 32'd1;
            end
            if (miss && full) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule
